// File: rtl/apa102_out.sv
// apa102_out: serialises a shadowed pixel buffer into an APA102 start/LED/end frame SPI stream.
module apa102_out #(
    parameter int LED_CNT = 7,
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [24*LED_CNT-1:0]  data,
    input  logic [4:0]             brightness,
    output logic                   sck,
    output logic                   sda,
    output logic                   busy,
    output logic                   done
);
    localparam int PW = $clog2(2*CLK_DIV);
    localparam int LW = $clog2(LED_CNT+1);
    localparam logic [PW-1:0] PH_LAST = PW'(2*CLK_DIV-1);
    localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV);
    localparam logic [LW-1:0] LED_LAST = LW'(LED_CNT-1);

    typedef enum logic [1:0] {IDLE, START_FRM, LED_FRM, END_FRM} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ph_q, ph_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [LW-1:0]          led_q, led_d;
    logic [24*LED_CNT-1:0]  shd_q, shd_d;
    logic [4:0]             br_q, br_d;
    logic                   sck_q, sck_d, sda_q, sda_d, busy_q, busy_d, done_q, done_d;
    logic [31:0]            word;
    logic                   bit_end, frm_end;

    always_comb begin
        word    = state_q == LED_FRM ? {3'b111, br_q, shd_q[24*LED_CNT-1 -: 24]} : {32{state_q == END_FRM}};
        bit_end = ph_q == PH_LAST;
        frm_end = bit_end && cnt_q == 5'd31;
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        shd_d   = shd_q;
        br_d    = br_q;
        sck_d   = 1'b0;
        sda_d   = sda_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            sda_d  = 1'b0;
            busy_d = 1'b0;
            if (start) begin
                shd_d   = data;
                br_d    = brightness;
                ph_d    = '0;
                cnt_d   = '0;
                led_d   = '0;
                busy_d  = 1'b1;
                state_d = START_FRM;
            end
        end else begin
            ph_d  = bit_end ? '0 : ph_q + 1'b1;
            sck_d = ph_d >= PH_HI;
            if (bit_end) begin
                cnt_d = cnt_q + 5'd1;
                // every frame after the start frame opens with a 1 (LED header or end frame)
                sda_d = frm_end ? 1'b1 : word[5'd30 - cnt_q];
            end
            if (frm_end) begin
                if (state_q == START_FRM) begin
                    state_d = LED_FRM;
                    led_d   = '0;
                end else if (state_q == LED_FRM) begin
                    shd_d   = shd_q << 24;
                    led_d   = led_q + LW'(1);
                    state_d = led_q == LED_LAST ? END_FRM : LED_FRM;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sda_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            shd_q   <= '0;
            br_q    <= '0;
            sck_q   <= 1'b0;
            sda_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            shd_q   <= shd_d;
            br_q    <= br_d;
            sck_q   <= sck_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sck  = sck_q;
    assign sda  = sda_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_apa102_out.sv
// tb_apa102_out: directed bench for apa102_out with a one-LED and a two-LED instance.
module tb_apa102_out;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [23:0] data1 = '0;
    logic [47:0] data2 = '0;
    logic [4:0]  br1 = '0, br2 = '0;
    logic        sck1, sda1, busy1, done1, sck2, sda2, busy2, done2;
    int          tests = 0, failed = 0;

    logic [95:0]  rx1 = '0;
    logic [127:0] rx2 = '0;
    int           n1 = 0, bc1 = 0, dc1 = 0, v1 = 0, n2 = 0, bc2 = 0, dc2 = 0, v2 = 0;
    logic         sck1_p = 1'b0, sda1_p = 1'b0, sck2_p = 1'b0, sda2_p = 1'b0;
    logic         clr_req = 1'b0;

    always #5 clk = ~clk;

    apa102_out #(.LED_CNT(1), .CLK_DIV(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data(data1), .brightness(br1),
        .sck(sck1), .sda(sda1), .busy(busy1), .done(done1));
    apa102_out #(.LED_CNT(2), .CLK_DIV(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .data(data2), .brightness(br2),
        .sck(sck2), .sda(sda2), .busy(busy2), .done(done2));

    // receiver model: shift sda in on each sck rise, flag sda moving while sck is high
    always @(negedge clk) begin
        if (clr_req) begin
            rx1 = '0; n1 = 0; bc1 = 0; dc1 = 0; v1 = 0;
            rx2 = '0; n2 = 0; bc2 = 0; dc2 = 0; v2 = 0;
        end else begin
            if (sck1 && !sck1_p) begin rx1 = {rx1[94:0], sda1}; n1++; end
            if (sck1 && sda1 !== sda1_p) v1++;
            if (busy1) bc1++;
            if (done1) dc1++;
            if (sck2 && !sck2_p) begin rx2 = {rx2[126:0], sda2}; n2++; end
            if (sck2 && sda2 !== sda2_p) v2++;
            if (busy2) bc2++;
            if (done2) dc2++;
        end
        sck1_p = sck1; sda1_p = sda1; sck2_p = sck2; sda2_p = sda2;
    end

    task automatic clr;
        clr_req = 1'b1;
        @(negedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic wait_done1(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done2(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done2) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        repeat (5) @(negedge clk) if ({sck1, sda1, busy1, done1, sck2, sda2, busy2, done2} !== 8'h00) bad++;
        tests++;
        if (bad !== 0) begin failed++; $display("FAIL reset_hold: %0d nonzero cycles, want 0", bad); end
        rst_n = 1'b1;
        bad = 0;
        repeat (100) @(negedge clk) if ({sck1, sda1, busy1, done1, sck2, sda2, busy2, done2} !== 8'h00) bad++;
        tests++;
        if (bad !== 0) begin failed++; $display("FAIL idle: %0d nonzero cycles, want 0", bad); end
    endtask

    task automatic test_single;
        bit ok;
        clr;
        data1 = 24'h112233; br1 = 5'h1F;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        tests++;
        if ({busy1, sck1, sda1} !== 3'b100) begin failed++; $display("FAIL accept: busy/sck/sda %b want 100", {busy1, sck1, sda1}); end
        wait_done1(1000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL single_timeout: done %b want 1", ok); end
        @(negedge clk);
        tests++;
        if (rx1 !== {32'h0, 32'hFF112233, 32'hFFFFFFFF}) begin failed++; $display("FAIL single_stream: got %h want %h", rx1, {32'h0, 32'hFF112233, 32'hFFFFFFFF}); end
        tests++;
        if (n1 !== 96) begin failed++; $display("FAIL single_bits: got %0d want 96", n1); end
        tests++;
        if (bc1 !== 384) begin failed++; $display("FAIL single_busy: got %0d want 384", bc1); end
        tests++;
        if (dc1 !== 1) begin failed++; $display("FAIL single_done: got %0d want 1", dc1); end
        tests++;
        if (v1 !== 0) begin failed++; $display("FAIL sda_stable: got %0d changes while sck high, want 0", v1); end
    endtask

    task automatic test_capture;
        bit ok;
        clr;
        data2 = {24'hAABBCC, 24'h010203}; br2 = 5'h03;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        @(negedge clk) begin data2 = '1; br2 = 5'h00; end
        wait_done2(2000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL capture_timeout: done %b want 1", ok); end
        @(negedge clk);
        tests++;
        if (rx2 !== {32'h0, 32'hE3AABBCC, 32'hE3010203, 32'hFFFFFFFF}) begin failed++; $display("FAIL capture_stream: got %h want %h", rx2, {32'h0, 32'hE3AABBCC, 32'hE3010203, 32'hFFFFFFFF}); end
        tests++;
        if (bc2 !== 512 || dc2 !== 1) begin failed++; $display("FAIL capture_busy: busy %0d done %0d want 512 1", bc2, dc2); end
        tests++;
        if (v2 !== 0) begin failed++; $display("FAIL capture_sda_stable: got %0d want 0", v2); end
    endtask

    task automatic test_busy_ignore;
        bit ok;
        int late = 0;
        clr;
        data1 = 24'hC0FFEE; br1 = 5'h10;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (100) @(negedge clk);
        data1 = 24'h123456; start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_done1(1000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL ignore_timeout: done %b want 1", ok); end
        @(negedge clk);
        tests++;
        if (rx1 !== {32'h0, 32'hF0C0FFEE, 32'hFFFFFFFF} || bc1 !== 384 || dc1 !== 1) begin
            failed++; $display("FAIL ignore_stream: got %h busy %0d done %0d want %h 384 1", rx1, bc1, dc1, {32'h0, 32'hF0C0FFEE, 32'hFFFFFFFF});
        end
        repeat (20) @(negedge clk) if (busy1) late++;
        tests++;
        if (late !== 0) begin failed++; $display("FAIL ignore_requeue: busy %0d cycles after done, want 0", late); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        clr;
        data1 = 24'h445566; br1 = 5'h01;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) data1 = 24'h778899;
        wait_done1(1000, ok);
        tests++;
        if (!ok || busy1 !== 1'b0) begin failed++; $display("FAIL b2b_first: done %b busy %b want 1 0", ok, busy1); end
        @(negedge clk);
        tests++;
        if ({busy1, sck1, sda1} !== 3'b100) begin failed++; $display("FAIL b2b_restart: busy/sck/sda %b want 100", {busy1, sck1, sda1}); end
        start1 = 1'b0;
        wait_done1(1000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL b2b_timeout: done %b want 1", ok); end
        @(negedge clk);
        tests++;
        if (rx1 !== {32'h0, 32'hE1778899, 32'hFFFFFFFF} || bc1 !== 768 || dc1 !== 2) begin
            failed++; $display("FAIL b2b_stream: got %h busy %0d done %0d want %h 768 2", rx1, bc1, dc1, {32'h0, 32'hE1778899, 32'hFFFFFFFF});
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        clr;
        data2 = {24'h102030, 24'h405060}; br2 = 5'h1F;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        repeat (150) @(negedge clk);
        for (int i = 0; i < 10 && !sck2; i++) @(negedge clk);
        tests++;
        if ({busy2, sck2} !== 2'b11) begin failed++; $display("FAIL mid_pre: busy/sck %b want 11", {busy2, sck2}); end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({sck2, sda2, busy2, done2} !== 4'h0) begin failed++; $display("FAIL mid_reset: sck/sda/busy/done %b want 0000", {sck2, sda2, busy2, done2}); end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clr;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        wait_done2(2000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL mid_timeout: done %b want 1", ok); end
        @(negedge clk);
        tests++;
        if (rx2 !== {32'h0, 32'hFF102030, 32'hFF405060, 32'hFFFFFFFF} || bc2 !== 512) begin
            failed++; $display("FAIL mid_stream: got %h busy %0d want %h 512", rx2, bc2, {32'h0, 32'hFF102030, 32'hFF405060, 32'hFFFFFFFF});
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_capture;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
